// File: rtl/race_progress_tracker_if.sv
// Race progress tracker bus: game state and lap pulse in, race telemetry out.
interface race_progress_tracker_if;
    logic [2:0]  state;
    logic        lap_pulse;
    logic [1:0]  countdown_digit;
    logic [15:0] race_time_cs;
    logic [3:0]  lap_count;
    logic [15:0] best_lap_cs;
    logic        time_overflow;
    logic        is_game_end;

    modport master (
        output state, lap_pulse,
        input  countdown_digit, race_time_cs, lap_count, best_lap_cs,
               time_overflow, is_game_end
    );

    modport slave (
        input  state, lap_pulse,
        output countdown_digit, race_time_cs, lap_count, best_lap_cs,
               time_overflow, is_game_end
    );
endinterface

// File: rtl/race_progress_tracker.sv
// Race progress tracker: countdown digit, centisecond race timer, lap counting
// with best-lap tracking, time-limit saturation and a registered race-over flag.
module race_progress_tracker #(
    parameter int TICKS_PER_CS  = 1_000_000,
    parameter int TICKS_PER_SEC = 100_000_000,
    parameter int TOTAL_LAPS    = 3,
    parameter int MAX_TIME_CS   = 59999
) (
    input logic                    clk,
    input logic                    rst,
    race_progress_tracker_if.slave bus
);
    localparam int PRESC_W = $clog2(TICKS_PER_CS + 1);
    localparam int SEC_W   = $clog2(TICKS_PER_SEC + 1);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_SETTING   = 3'd1;
    localparam logic [2:0] ST_COUNTDOWN = 3'd3;
    localparam logic [2:0] ST_RACING    = 3'd4;
    localparam logic [2:0] ST_PAUSE     = 3'd5;

    logic [2:0]         prev_state_r;
    logic [SEC_W-1:0]   sec_cnt_r;
    logic [PRESC_W-1:0] presc_r;
    logic [1:0]         digit_r;
    logic [15:0]        race_time_r;
    logic [15:0]        lap_start_r;
    logic [3:0]         lap_count_r;
    logic [15:0]        best_lap_r;
    logic               time_overflow_r;
    logic               is_game_end_r;

    logic               cs_tick_s;
    logic               sec_tick_s;
    logic               laps_done_s;
    logic               lap_accept_s;
    logic               countdown_entry_s;
    logic               time_can_run_s;
    logic [15:0]        lap_time_s;

    // Derived per-cycle events: prescaler wraps, lap acceptance and lap duration.
    always_comb begin
        cs_tick_s         = (presc_r == PRESC_W'(TICKS_PER_CS - 1));
        sec_tick_s        = (sec_cnt_r == SEC_W'(TICKS_PER_SEC - 1));
        laps_done_s       = (lap_count_r == 4'(TOTAL_LAPS));
        lap_accept_s      = (bus.state == ST_RACING) && bus.lap_pulse && !laps_done_s;
        // Resuming from PAUSE must not restart the countdown.
        countdown_entry_s = (prev_state_r != ST_COUNTDOWN) && (prev_state_r != ST_PAUSE);
        time_can_run_s    = !laps_done_s && (race_time_r < 16'(MAX_TIME_CS));
        // lap_start never exceeds race_time, so this cannot wrap.
        lap_time_s        = race_time_r - lap_start_r;
    end

    // Main race state: countdown, timer, laps and end-of-race flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_state_r    <= ST_IDLE;
            sec_cnt_r       <= '0;
            presc_r         <= '0;
            digit_r         <= 2'd0;
            race_time_r     <= 16'd0;
            lap_start_r     <= 16'd0;
            lap_count_r     <= 4'd0;
            best_lap_r      <= 16'hFFFF;
            time_overflow_r <= 1'b0;
            is_game_end_r   <= 1'b0;
        end else begin
            prev_state_r <= bus.state;
            case (bus.state)
                ST_IDLE, ST_SETTING: begin
                    sec_cnt_r       <= '0;
                    presc_r         <= '0;
                    digit_r         <= 2'd0;
                    race_time_r     <= 16'd0;
                    lap_start_r     <= 16'd0;
                    lap_count_r     <= 4'd0;
                    best_lap_r      <= 16'hFFFF;
                    time_overflow_r <= 1'b0;
                    is_game_end_r   <= 1'b0;
                end
                ST_COUNTDOWN: begin
                    // Prescaler parked at 0 so racing starts on a clean cs boundary.
                    presc_r <= '0;
                    if (countdown_entry_s) begin
                        sec_cnt_r <= '0;
                        digit_r   <= 2'd3;
                    end else if (sec_tick_s) begin
                        sec_cnt_r <= '0;
                        if (digit_r > 2'd1) begin
                            digit_r <= digit_r - 2'd1;
                        end else begin
                            digit_r <= digit_r;
                        end
                    end else begin
                        sec_cnt_r <= sec_cnt_r + SEC_W'(1);
                    end
                end
                ST_RACING: begin
                    digit_r <= 2'd0;
                    if (cs_tick_s) begin
                        presc_r <= '0;
                    end else begin
                        presc_r <= presc_r + PRESC_W'(1);
                    end
                    if (cs_tick_s && time_can_run_s) begin
                        race_time_r <= race_time_r + 16'd1;
                        if (race_time_r == 16'(MAX_TIME_CS - 1)) begin
                            time_overflow_r <= 1'b1;
                        end
                    end
                    // The lap uses the pre-update time even when a cs tick lands together.
                    if (lap_accept_s) begin
                        lap_count_r <= lap_count_r + 4'd1;
                        lap_start_r <= race_time_r;
                        if (lap_time_s < best_lap_r) begin
                            best_lap_r <= lap_time_s;
                        end
                    end
                    is_game_end_r <= is_game_end_r | laps_done_s | time_overflow_r;
                end
                default: begin
                    // PAUSE, FINISH and undefined codes hold every register.
                end
            endcase
        end
    end

    assign bus.countdown_digit = digit_r;
    assign bus.race_time_cs    = race_time_r;
    assign bus.lap_count       = lap_count_r;
    assign bus.best_lap_cs     = best_lap_r;
    assign bus.time_overflow   = time_overflow_r;
    assign bus.is_game_end     = is_game_end_r;
endmodule

// File: tb/tb_race_progress_tracker.sv
// Bench for race_progress_tracker: directed scenarios plus random state/pulse
// traffic, all checked against a behavioural race model.
module tb_race_progress_tracker;
    localparam int TPC   = 4;
    localparam int TPS   = 10;
    localparam int LAPS  = 2;
    localparam int MAXT  = 20;

    logic clk;
    logic rst;
    race_progress_tracker_if bus ();

    race_progress_tracker #(
        .TICKS_PER_CS (TPC),
        .TICKS_PER_SEC(TPS),
        .TOTAL_LAPS   (LAPS),
        .MAX_TIME_CS  (MAXT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp;
    int n_err;

    // Observed outputs packed as {digit, time, laps, best, overflow, end}.
    logic [39:0] obs;
    assign obs = {bus.countdown_digit, bus.race_time_cs, bus.lap_count,
                  bus.best_lap_cs, bus.time_overflow, bus.is_game_end};

    // Behavioural model of the race.
    int m_digit, m_cd, m_edges, m_time, m_laps, m_start, m_best, m_end, m_prev;
    bit m_cd_active;

    function automatic logic [39:0] model_vec();
        logic [1:0]  d;
        logic [15:0] t;
        logic [3:0]  l;
        logic [15:0] b;
        d = m_digit[1:0];
        t = m_time[15:0];
        l = m_laps[3:0];
        b = m_best[15:0];
        return {d, t, l, b, 1'(m_time == MAXT), 1'(m_end != 0)};
    endfunction

    task automatic model_step(input logic r, input int st, input logic pl);
        int lap;
        int old_time;
        int old_laps;
        if (r || st == 0 || st == 1) begin
            m_digit = 0; m_cd = 0; m_edges = 0; m_time = 0; m_laps = 0;
            m_start = 0; m_best = 16'hFFFF; m_end = 0; m_cd_active = 0;
        end else if (st == 3) begin
            if (m_prev != 3 && m_prev != 5) begin
                m_cd_active = 1;
                m_cd = 0;
            end else if (m_cd_active) begin
                m_cd++;
            end
            if (m_cd_active) m_digit = (m_cd / TPS >= 2) ? 1 : 3 - m_cd / TPS;
            m_edges = m_time * TPC;
        end else if (st == 4) begin
            old_time = m_time;
            old_laps = m_laps;
            if (old_laps == LAPS || old_time == MAXT) m_end = 1;
            if (pl && old_laps < LAPS) begin
                lap = old_time - m_start;
                m_laps++;
                m_start = old_time;
                if (lap < m_best) m_best = lap;
            end
            if (old_laps < LAPS) begin
                m_edges++;
                m_time = (m_edges / TPC > MAXT) ? MAXT : m_edges / TPC;
            end
            m_digit = 0;
            m_cd_active = 0;
        end
        m_prev = r ? 0 : st;
    endtask

    task automatic tick(input logic r, input logic [2:0] st, input logic pl);
        rst = r;
        bus.state = st;
        bus.lap_pulse = pl;
        @(posedge clk);
        model_step(r, int'(st), pl);
        #1;
    endtask

    task automatic test_reset();
        tick(1'b1, 3'd4, 1'b0);
        n_cmp++;
        if (obs !== {2'd0, 16'd0, 4'd0, 16'hFFFF, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL reset_state: got %h expected %h", obs, {2'd0, 16'd0, 4'd0, 16'hFFFF, 1'b0, 1'b0});
        end
    endtask

    task automatic test_countdown();
        logic [1:0] exp_d;
        tick(1'b0, 3'd0, 1'b0);
        for (int k = 0; k < 30; k++) begin
            tick(1'b0, 3'd3, 1'b0);
            exp_d = (k < 10) ? 2'd3 : ((k < 20) ? 2'd2 : 2'd1);
            n_cmp++;
            if ({bus.countdown_digit, bus.race_time_cs} !== {exp_d, 16'd0}) begin
                n_err++;
                $display("FAIL countdown_k%0d: got digit %0d time %0d expected digit %0d time 0",
                         k, bus.countdown_digit, bus.race_time_cs, exp_d);
            end
        end
    endtask

    task automatic test_racing_pause();
        for (int k = 0; k < 40; k++) tick(1'b0, 3'd4, 1'b0);
        n_cmp++;
        if ({bus.countdown_digit, bus.race_time_cs} !== {2'd0, 16'd10}) begin
            n_err++;
            $display("FAIL racing_40: got digit %0d time %0d expected 0 10", bus.countdown_digit, bus.race_time_cs);
        end
        for (int k = 0; k < 20; k++) tick(1'b0, 3'd5, 1'b0);
        n_cmp++;
        if (bus.race_time_cs !== 16'd10) begin
            n_err++;
            $display("FAIL pause_hold: got %0d expected 10", bus.race_time_cs);
        end
        for (int k = 0; k < 4; k++) tick(1'b0, 3'd4, 1'b0);
        n_cmp++;
        if (bus.race_time_cs !== 16'd11) begin
            n_err++;
            $display("FAIL resume: got %0d expected 11", bus.race_time_cs);
        end
    endtask

    task automatic test_laps();
        tick(1'b1, 3'd0, 1'b0);
        tick(1'b0, 3'd3, 1'b0);
        for (int k = 0; k < 200 && m_time != 5; k++) tick(1'b0, 3'd4, 1'b0);
        tick(1'b0, 3'd4, 1'b1);
        n_cmp++;
        if ({bus.lap_count, bus.best_lap_cs} !== {4'd1, 16'd5}) begin
            n_err++;
            $display("FAIL lap1: got laps %0d best %0d expected 1 5", bus.lap_count, bus.best_lap_cs);
        end
        for (int k = 0; k < 200 && m_time != 12; k++) tick(1'b0, 3'd4, 1'b0);
        tick(1'b0, 3'd4, 1'b1);
        n_cmp++;
        if ({bus.lap_count, bus.best_lap_cs, bus.is_game_end} !== {4'd2, 16'd5, 1'b0}) begin
            n_err++;
            $display("FAIL lap2: got laps %0d best %0d end %0b expected 2 5 0",
                     bus.lap_count, bus.best_lap_cs, bus.is_game_end);
        end
        tick(1'b0, 3'd4, 1'b0);
        n_cmp++;
        if (bus.is_game_end !== 1'b1) begin
            n_err++;
            $display("FAIL lap_game_end: got %0b expected 1", bus.is_game_end);
        end
        for (int k = 0; k < 20; k++) tick(1'b0, 3'd4, 1'b0);
        n_cmp++;
        if (bus.race_time_cs !== 16'd12) begin
            n_err++;
            $display("FAIL lap_freeze: got %0d expected 12", bus.race_time_cs);
        end
    endtask

    task automatic test_overflow();
        tick(1'b1, 3'd0, 1'b0);
        tick(1'b0, 3'd3, 1'b0);
        for (int k = 0; k < 79; k++) tick(1'b0, 3'd4, 1'b0);
        n_cmp++;
        if ({bus.race_time_cs, bus.time_overflow} !== {16'd19, 1'b0}) begin
            n_err++;
            $display("FAIL ovf_before: got time %0d ovf %0b expected 19 0", bus.race_time_cs, bus.time_overflow);
        end
        tick(1'b0, 3'd4, 1'b0);
        n_cmp++;
        if ({bus.race_time_cs, bus.time_overflow, bus.is_game_end} !== {16'd20, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL ovf_hit: got time %0d ovf %0b end %0b expected 20 1 0",
                     bus.race_time_cs, bus.time_overflow, bus.is_game_end);
        end
        for (int k = 0; k < 20; k++) tick(1'b0, 3'd4, 1'b0);
        n_cmp++;
        if ({bus.race_time_cs, bus.time_overflow, bus.is_game_end} !== {16'd20, 1'b1, 1'b1}) begin
            n_err++;
            $display("FAIL ovf_sat: got time %0d ovf %0b end %0b expected 20 1 1",
                     bus.race_time_cs, bus.time_overflow, bus.is_game_end);
        end
    endtask

    task automatic test_ignored_pulses();
        tick(1'b1, 3'd0, 1'b0);
        for (int k = 0; k < 3; k++) tick(1'b0, 3'd3, 1'b1);
        for (int k = 0; k < 8; k++) tick(1'b0, 3'd4, 1'b0);
        tick(1'b0, 3'd5, 1'b1);
        n_cmp++;
        if (bus.lap_count !== 4'd0) begin
            n_err++;
            $display("FAIL ignore_cd_pause: got %0d expected 0", bus.lap_count);
        end
        tick(1'b0, 3'd4, 1'b1);
        tick(1'b0, 3'd2, 1'b1);
        tick(1'b0, 3'd7, 1'b1);
        n_cmp++;
        if ({bus.lap_count, bus.best_lap_cs} !== {4'd1, 16'd2}) begin
            n_err++;
            $display("FAIL ignore_undef: got laps %0d best %0d expected 1 2", bus.lap_count, bus.best_lap_cs);
        end
        for (int k = 0; k < 4; k++) tick(1'b0, 3'd4, 1'b0);
        tick(1'b0, 3'd4, 1'b1);
        tick(1'b0, 3'd6, 1'b1);
        tick(1'b0, 3'd4, 1'b1);
        n_cmp++;
        if ({bus.lap_count, bus.best_lap_cs} !== {4'd2, 16'd1}) begin
            n_err++;
            $display("FAIL ignore_third: got laps %0d best %0d expected 2 1", bus.lap_count, bus.best_lap_cs);
        end
    endtask

    task automatic test_idle_clear();
        tick(1'b0, 3'd6, 1'b0);
        tick(1'b0, 3'd0, 1'b0);
        n_cmp++;
        if (obs !== {2'd0, 16'd0, 4'd0, 16'hFFFF, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL idle_clear: got %h expected %h", obs, {2'd0, 16'd0, 4'd0, 16'hFFFF, 1'b0, 1'b0});
        end
        tick(1'b0, 3'd3, 1'b0);
        for (int k = 0; k < 30; k++) tick(1'b0, 3'd4, (k == 20) ? 1'b1 : 1'b0);
        tick(1'b1, 3'd4, 1'b0);
        n_cmp++;
        if (obs !== {2'd0, 16'd0, 4'd0, 16'hFFFF, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL rst_mid_race: got %h expected %h", obs, {2'd0, 16'd0, 4'd0, 16'hFFFF, 1'b0, 1'b0});
        end
    endtask

    task automatic test_random();
        logic [2:0] st;
        logic [2:0] map [16] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd4, 3'd4,
                                 3'd4, 3'd4, 3'd4, 3'd5, 3'd5, 3'd6, 3'd7, 3'd4};
        logic [39:0] exp_v;
        st = 3'd0;
        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(0, 11) == 0) st = map[$urandom_range(0, 15)];
            tick(($urandom_range(0, 599) == 0) ? 1'b1 : 1'b0, st,
                 ($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0);
            exp_v = model_vec();
            n_cmp++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL random_cycle%0d: got %h expected %h (state %0d)", k, obs, exp_v, st);
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        bus.state = 3'd0;
        bus.lap_pulse = 1'b0;
        m_prev = 0;
        test_reset();
        test_countdown();
        test_racing_pause();
        test_laps();
        test_overflow();
        test_ignored_pulses();
        test_idle_clear();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
